if_prefetch_unit: RTL

Instruction-fetch front end for the pipelined RISC-V core. Issues in-order word reads to instruction memory over a request/grant/valid handshake and buffers returned words in a DEPTH-entry prefetch FIFO. Presents one instruction per cycle, tagged with its PC, to the IF/ID register of the pipeline. Handles branch redirects by flushing the FIFO and discarding stale in-flight responses, and stops fetching on halt.

---
 rtl/if_pkg.sv | 24 ++
 rtl/if_fifo.sv | 50 +++++
 rtl/if_prefetch_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: NOP constant, fetch FSM states, FIFO entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential fetch advances one word; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of fetch entries with push/pop/flush and an occupancy count.
// Latency: write lands at the clock edge; head is read combinationally.
// Backpressure: none internally; the caller's credit scheme keeps push off a full FIFO.
import if_pkg::*;

module if_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  assign head = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO regardless of push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: in-order word reads, DEPTH-entry prefetch FIFO, redirect flush, halt drain.
// Latency: grant N, rvalid N+k -> inst_valid N+k+1; redirect R -> first request R+1, earliest instruction R+3.
// Backpressure: stall holds the head; requests stop once buffered+outstanding reaches DEPTH. Optional IF_PREFETCH_PERF_EN adds counters.
import if_pkg::*;

module if_prefetch_unit #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  input  logic              halt,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              halted
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_discarded,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic          credit_ok;
  logic          xfer;
  logic          keep;
  logic          pop;
  logic          drain_done;
  logic          unused_bits;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign unused_bits  = ^redirect_pc[1:0];

  // Buffered words plus words still in flight never exceed DEPTH, so a response always has a slot.
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign xfer       = imem_req & imem_gnt;
  assign out_nxt    = outstanding + CW'(xfer) - CW'(imem_rvalid);
  // No requests issue outside FETCH, so draining only needs the response side.
  assign drain_done = (outstanding - CW'(imem_rvalid)) == '0;

  // Stale responses (discard>0) and the one landing in a redirect cycle are dropped.
  assign keep       = imem_rvalid & (discard == '0) & ~redirect_valid;
  assign inst_valid = fifo_count != '0;
  assign pop        = inst_valid & ~stall & ~redirect_valid;
  assign push_entry = '{inst: imem_rdata, pc: rsp_pc};

  assign imem_addr  = fetch_pc;
  assign inst       = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc   : 32'h0;

  if_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next state and request/halted outputs; redirect overrides everything, halt blocks new requests at once.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = reset & ~redirect_valid & ~halt & credit_ok;
        if (halt) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
      IDLE: begin
        halted = (outstanding == '0);
      end
      default: state_nxt = FETCH;
    endcase
    if (redirect_valid) state_nxt = FETCH;
  end

  // Request/response bookkeeping: fetch PC, response-side PC, in-flight and stale-response counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= PC_RESET;
      rsp_pc      <= PC_RESET;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        discard  <= out_nxt;
      end else begin
        if (xfer) fetch_pc <= pc_inc(fetch_pc);
        if (keep) rsp_pc <= pc_inc(rsp_pc);
        if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
      end
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched      <= '0;
      perf_discarded    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (keep && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (imem_rvalid && !keep && perf_discarded != '1) perf_discarded <= perf_discarded + 32'd1;
      if (state == FETCH && !inst_valid && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
